// File: rtl/pong_engine_pkg.sv
// Shared definitions for the pong game-logic block: screen geometry, FSM
// state encoding, display bus addresses and the score helper.
package pong_engine_pkg;

    // Geometry in display coordinates (x = row, y = column).
    localparam int X_MAX        = 480;
    localparam int Y_MAX        = 640;
    localparam int BORDER       = 10;
    localparam int BALL         = 10;
    localparam int PAD_H        = 40;
    localparam int PAD_W        = 10;
    localparam int PAD1_Y       = 30;
    localparam int PAD2_Y       = 600;
    localparam int PAD_STEP     = 4;
    localparam int BALL_STEP    = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    // Display bus widths and register addresses.
    localparam int ADDR_W = 2;
    localparam int DATA_W = 10;
    localparam logic [1:0] ADDR_BALL_X = 2'd0;
    localparam logic [1:0] ADDR_BALL_Y = 2'd1;
    localparam logic [1:0] ADDR_PAD_1  = 2'd2;
    localparam logic [1:0] ADDR_PAD_2  = 2'd3;

    // Signed working coordinate: wide enough that ball stepping never wraps.
    typedef logic signed [10:0] coord_t;

    localparam coord_t C_BORDER     = coord_t'(BORDER);
    localparam coord_t C_BALL       = coord_t'(BALL);
    localparam coord_t C_PAD_H      = coord_t'(PAD_H);
    localparam coord_t C_PAD_W      = coord_t'(PAD_W);
    localparam coord_t C_PAD1_Y     = coord_t'(PAD1_Y);
    localparam coord_t C_PAD2_Y     = coord_t'(PAD2_Y);
    localparam coord_t C_BALL_STEP  = coord_t'(BALL_STEP);
    localparam coord_t C_BALL_X_MAX = coord_t'(X_MAX - BORDER - BALL);
    localparam coord_t C_PAD1_FACE  = coord_t'(PAD1_Y + PAD_W);
    localparam coord_t C_PAD2_FACE  = coord_t'(PAD2_Y - BALL);
    localparam coord_t C_WALL_R     = coord_t'(Y_MAX - BORDER);
    localparam coord_t C_BALL_X0    = coord_t'(235);
    localparam coord_t C_BALL_Y0    = coord_t'(315);

    // Register-width constants.
    localparam logic [8:0] PAD_MIN    = 9'(BORDER);
    localparam logic [8:0] PAD_MAX    = 9'(X_MAX - BORDER - PAD_H);
    localparam logic [8:0] PAD_INIT   = 9'd220;
    localparam logic [8:0] PAD_STEP_V = 9'(PAD_STEP);
    localparam logic [8:0] BALL_X0    = 9'd235;
    localparam logic [9:0] BALL_Y0    = 10'd315;
    localparam logic [5:0] SERVE_LOAD = 6'(SERVE_FRAMES);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    // One frame of work: move paddles, step ball, resolve collisions, publish.
    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_PADDLE = 3'd1,
        ST_BALL   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_WR0    = 3'd4,
        ST_WR1    = 3'd5,
        ST_WR2    = 3'd6,
        ST_WR3    = 3'd7
    } state_t;

    // Score increment that stops at the winning score.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s >= WIN) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_engine_if.sv
// Write bus from the game engine to the VGA display block.
// sel is a one-cycle write strobe; addr/data_out are meaningful only while
// sel is high. There is no back-pressure: the display accepts every write.
interface pong_engine_if;
    import pong_engine_pkg::*;

    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;

    modport master (output sel, output addr, output data_out);
    modport slave  (input  sel, input  addr, input  data_out);
endinterface

// File: rtl/pong_engine_paddle_ctrl.sv
// One paddle: moves by a fixed step on each tick from level up/down buttons,
// clamped to the playfield. Pressing both buttons (or neither) holds position.
module pong_engine_paddle_ctrl #(
    parameter logic [8:0] P_MIN  = 9'd10,
    parameter logic [8:0] P_MAX  = 9'd430,
    parameter logic [8:0] P_INIT = 9'd220,
    parameter logic [8:0] P_STEP = 9'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_up,
    input  logic       i_dn,
    output logic [8:0] o_pos
);

    logic [8:0] r_pos;
    logic [8:0] w_next;

    // Next position with clamping at both ends of travel.
    always_comb begin
        w_next = r_pos;
        if (i_up && !i_dn) begin
            w_next = (r_pos >= P_MIN + P_STEP) ? r_pos - P_STEP : P_MIN;
        end else if (i_dn && !i_up) begin
            w_next = (r_pos + P_STEP <= P_MAX) ? r_pos + P_STEP : P_MAX;
        end
    end

    // Position register, updated once per frame on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= P_INIT;
        end else if (i_tick) begin
            r_pos <= w_next;
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/pong_engine.sv
// Pong game-logic stage. Once per frame_tick it moves both paddles, steps the
// ball, resolves wall/paddle/miss events, keeps score, then publishes ball_x,
// ball_y, paddle_1 and paddle_2 to the display as four consecutive writes.
module pong_engine
    import pong_engine_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_frame_tick,
    input  logic                 i_start,
    input  logic                 i_p1_up,
    input  logic                 i_p1_dn,
    input  logic                 i_p2_up,
    input  logic                 i_p2_dn,
    pong_engine_if.master        bus,
    output logic [3:0]           o_score1,
    output logic [3:0]           o_score2,
    output logic                 o_game_over,
    output state_t               o_state
);

    // FSM
    state_t r_state;
    state_t w_state_next;

    // Ball state: direction flags are 1 for +1, 0 for -1.
    logic [8:0] r_ball_x;
    logic [9:0] r_ball_y;
    logic       r_dx;
    logic       r_dy;
    logic [5:0] r_serve_cnt;

    // Tentative step computed in BALL, resolved in CHECK.
    coord_t     r_nx;
    coord_t     r_ny;
    logic       r_step_vld;

    logic [3:0] r_score1;
    logic [3:0] r_score2;
    logic       r_game_over;

    // Frame snapshot driven onto the bus during WR0..WR3.
    logic [8:0] r_wr_bx;
    logic [9:0] r_wr_by;
    logic [8:0] r_wr_p1;
    logic [8:0] r_wr_p2;

    logic [8:0] w_pad1;
    logic [8:0] w_pad2;
    coord_t     w_pad1_c;
    coord_t     w_pad2_c;
    coord_t     w_bx_c;
    coord_t     w_by_c;

    // CHECK results
    coord_t     w_cx;
    logic       w_cdx;
    logic       w_ov1;
    logic       w_ov2;
    coord_t     w_bx_next;
    coord_t     w_by_next;
    logic       w_dx_next;
    logic       w_dy_next;
    logic [3:0] w_s1_next;
    logic [3:0] w_s2_next;
    logic       w_go_next;
    logic       w_reserve;
    logic       w_unused;

    assign w_pad1_c = coord_t'({2'b00, w_pad1});
    assign w_pad2_c = coord_t'({2'b00, w_pad2});
    assign w_bx_c   = coord_t'({2'b00, r_ball_x});
    assign w_by_c   = coord_t'({1'b0, r_ball_y});

    // Upper bits of resolved coordinates are always zero after clamping.
    assign w_unused = &{1'b0, w_bx_next[10:9], w_by_next[10]};

    pong_engine_paddle_ctrl #(
        .P_MIN (PAD_MIN),
        .P_MAX (PAD_MAX),
        .P_INIT(PAD_INIT),
        .P_STEP(PAD_STEP_V)
    ) u_pad1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tick(r_state == ST_PADDLE),
        .i_up  (i_p1_up),
        .i_dn  (i_p1_dn),
        .o_pos (w_pad1)
    );

    pong_engine_paddle_ctrl #(
        .P_MIN (PAD_MIN),
        .P_MAX (PAD_MAX),
        .P_INIT(PAD_INIT),
        .P_STEP(PAD_STEP_V)
    ) u_pad2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tick(r_state == ST_PADDLE),
        .i_up  (i_p2_up),
        .i_dn  (i_p2_dn),
        .o_pos (w_pad2)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: only WAIT looks at frame_tick, every other state lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT:   if (i_frame_tick) w_state_next = ST_PADDLE;
            ST_PADDLE: w_state_next = ST_BALL;
            ST_BALL:   w_state_next = ST_CHECK;
            ST_CHECK:  w_state_next = ST_WR0;
            ST_WR0:    w_state_next = ST_WR1;
            ST_WR1:    w_state_next = ST_WR2;
            ST_WR2:    w_state_next = ST_WR3;
            ST_WR3:    w_state_next = ST_WAIT;
            default:   w_state_next = ST_WAIT;
        endcase
    end

    // Bus outputs decoded from state so sel falls with the async reset.
    always_comb begin
        bus.sel      = 1'b0;
        bus.addr     = ADDR_BALL_X;
        bus.data_out = '0;
        case (r_state)
            ST_WR0: begin
                bus.sel      = 1'b1;
                bus.addr     = ADDR_BALL_X;
                bus.data_out = {1'b0, r_wr_bx};
            end
            ST_WR1: begin
                bus.sel      = 1'b1;
                bus.addr     = ADDR_BALL_Y;
                bus.data_out = r_wr_by;
            end
            ST_WR2: begin
                bus.sel      = 1'b1;
                bus.addr     = ADDR_PAD_1;
                bus.data_out = {1'b0, r_wr_p1};
            end
            ST_WR3: begin
                bus.sel      = 1'b1;
                bus.addr     = ADDR_PAD_2;
                bus.data_out = {1'b0, r_wr_p2};
            end
            default: ;
        endcase
    end

    // Collision resolution: x walls first, then paddles, then misses.
    // Paddle tests use the wall-clamped x so both clamps can apply together.
    always_comb begin
        w_cx      = r_nx;
        w_cdx     = r_dx;
        w_ov1     = 1'b0;
        w_ov2     = 1'b0;
        w_bx_next = w_bx_c;
        w_by_next = w_by_c;
        w_dx_next = r_dx;
        w_dy_next = r_dy;
        w_s1_next = r_score1;
        w_s2_next = r_score2;
        w_reserve = 1'b0;

        if (w_cx <= C_BORDER) begin
            w_cx  = C_BORDER;
            w_cdx = 1'b1;
        end else if (w_cx >= C_BALL_X_MAX) begin
            w_cx  = C_BALL_X_MAX;
            w_cdx = 1'b0;
        end

        w_ov1 = (w_cx + C_BALL > w_pad1_c) && (w_cx < w_pad1_c + C_PAD_H);
        w_ov2 = (w_cx + C_BALL > w_pad2_c) && (w_cx < w_pad2_c + C_PAD_H);

        if (r_step_vld) begin
            w_bx_next = w_cx;
            w_dx_next = w_cdx;
            if (!r_dy && (r_ny <= C_PAD1_FACE) && (r_ny + C_BALL > C_PAD1_Y) && w_ov1) begin
                w_by_next = C_PAD1_FACE;
                w_dy_next = 1'b1;
            end else if (r_dy && (r_ny + C_BALL >= C_PAD2_Y) && (r_ny < C_PAD2_Y + C_PAD_W) && w_ov2) begin
                w_by_next = C_PAD2_FACE;
                w_dy_next = 1'b0;
            end else if (r_ny <= C_BORDER) begin
                // Player 1 conceded: re-serve toward player 1.
                w_s2_next = score_inc(r_score2);
                w_bx_next = C_BALL_X0;
                w_by_next = C_BALL_Y0;
                w_dy_next = 1'b0;
                w_reserve = 1'b1;
            end else if (r_ny + C_BALL >= C_WALL_R) begin
                // Player 2 conceded: re-serve toward player 2.
                w_s1_next = score_inc(r_score1);
                w_bx_next = C_BALL_X0;
                w_by_next = C_BALL_Y0;
                w_dy_next = 1'b1;
                w_reserve = 1'b1;
            end else begin
                w_by_next = r_ny;
            end
        end

        w_go_next = r_game_over || (w_s1_next == WIN) || (w_s2_next == WIN);
    end

    // Ball, score and snapshot registers; start overrides the frame pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ball_x    <= BALL_X0;
            r_ball_y    <= BALL_Y0;
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_serve_cnt <= SERVE_LOAD;
            r_nx        <= '0;
            r_ny        <= '0;
            r_step_vld  <= 1'b0;
            r_score1    <= '0;
            r_score2    <= '0;
            r_game_over <= 1'b0;
            r_wr_bx     <= BALL_X0;
            r_wr_by     <= BALL_Y0;
            r_wr_p1     <= PAD_INIT;
            r_wr_p2     <= PAD_INIT;
        end else if (i_start) begin
            r_ball_x    <= BALL_X0;
            r_ball_y    <= BALL_Y0;
            r_serve_cnt <= SERVE_LOAD;
            r_step_vld  <= 1'b0;
            r_score1    <= '0;
            r_score2    <= '0;
            r_game_over <= 1'b0;
            r_wr_bx     <= BALL_X0;
            r_wr_by     <= BALL_Y0;
        end else begin
            case (r_state)
                ST_BALL: begin
                    r_step_vld <= 1'b0;
                    if (!r_game_over) begin
                        if (r_serve_cnt != 6'd0) begin
                            r_serve_cnt <= r_serve_cnt - 6'd1;
                        end else begin
                            r_nx       <= w_bx_c + (r_dx ? C_BALL_STEP : -C_BALL_STEP);
                            r_ny       <= w_by_c + (r_dy ? C_BALL_STEP : -C_BALL_STEP);
                            r_step_vld <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    r_ball_x    <= w_bx_next[8:0];
                    r_ball_y    <= w_by_next[9:0];
                    r_dx        <= w_dx_next;
                    r_dy        <= w_dy_next;
                    r_score1    <= w_s1_next;
                    r_score2    <= w_s2_next;
                    r_game_over <= w_go_next;
                    r_step_vld  <= 1'b0;
                    if (w_reserve) r_serve_cnt <= SERVE_LOAD;
                    r_wr_bx     <= w_bx_next[8:0];
                    r_wr_by     <= w_by_next[9:0];
                    r_wr_p1     <= w_pad1;
                    r_wr_p2     <= w_pad2;
                end
                default: ;
            endcase
        end
    end

    assign o_score1    = r_score1;
    assign o_score2    = r_score2;
    assign o_game_over = r_game_over;
    assign o_state     = r_state;

endmodule
